// File: rtl/serial_adder_n.sv
// Multi-cycle adder: A + B + c_in computed CHUNK bits per clock, LSB slice first.
// Define SERIAL_ADD_OVF_EN to build the signed-overflow flag; otherwise ovf is tied low.
module serial_adder_n #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);
  localparam int NSL = WIDTH / CHUNK;
  localparam int CW  = $clog2(NSL + 1);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] a_reg, b_reg, res_reg, res_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [CHUNK:0]   slice;
  logic             last;

  // Slice sum enters the result register from the top, so after NSL slices
  // the first (LSB) slice has been shifted down to bit 0.
  always_comb begin
    slice   = {1'b0, a_reg[CHUNK-1:0]} + {1'b0, b_reg[CHUNK-1:0]} + (CHUNK+1)'(carry);
    res_nxt = (res_reg >> CHUNK) | (WIDTH'(slice[CHUNK-1:0]) << (WIDTH - CHUNK));
    last    = (cnt == CW'(NSL - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      res_reg <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      done    <= 1'b0;
      sum     <= '0;
      c_out   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a_reg   <= a;
          b_reg   <= b;
          carry   <= c_in;
          res_reg <= '0;
          cnt     <= '0;
        end
        RUN: begin
          a_reg   <= a_reg >> CHUNK;
          b_reg   <= b_reg >> CHUNK;
          res_reg <= res_nxt;
          carry   <= slice[CHUNK];
          cnt     <= cnt + 1'b1;
          if (last) begin
            sum   <= res_nxt;
            c_out <= slice[CHUNK];
            done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  // Operand MSBs are kept separately because a_reg/b_reg are shifted away.
  logic a_msb, b_msb;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
      end
      if (state == RUN && last)
        ovf <= (a_msb == b_msb) && (res_nxt[WIDTH-1] != a_msb);
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: doc/serial_adder_n.md
Name: serial_adder_n

Overview:
- Multi-cycle N-bit adder that computes A + B + c_in one CHUNK-bit slice per clock, LSB slice first.
- Carry is held in a register between slices.
- Uses a start/busy/done handshake.
- Generalises the single-bit full-adder cell to arbitrary width, trading latency for area.
- Sits in datapaths where a wide ripple adder is too large or too slow for one cycle.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be ≥ 1.
- CHUNK, 1, bits added per cycle; must divide WIDTH exactly; CHUNK = WIDTH gives a single-cycle registered adder.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request; sampled only when busy = 0.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- c_in  input  1  carry-in; captured on accepted start.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse when sum/c_out become valid.
- sum  output  WIDTH  result A + B + c_in modulo 2^WIDTH.
- c_out  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow flag (see Optional Feature).

Behaviour:
- Reset: state = IDLE. busy = 0, done = 0, sum = 0, c_out = 0, ovf = 0. Internal operand, carry and slice-counter registers are cleared.
- Slice count: NSL = WIDTH/CHUNK. Counter width is clog2(NSL+1).
- FSM states: IDLE, RUN.
- IDLE:
  - If start = 1 at edge E0: capture a, b and c_in; load carry register with c_in; clear the result shift register; counter = 0; go to RUN.
  - busy = 1 from E0.
- RUN, on each edge:
  - Add low CHUNK bits of A-reg, low CHUNK bits of B-reg and the carry register, giving CHUNK+1 bits.
  - Shift the CHUNK sum bits into the top of the result register (right shift).
  - Right-shift A-reg and B-reg by CHUNK.
  - Carry register = bit CHUNK of the slice sum.
  - Increment counter.
- Completion at edge E0+NSL, when the last slice is processed:
  - sum = full result, c_out = final carry; update ovf.
  - done = 1 for exactly one cycle; busy = 0; go to IDLE.
  - Latency: done is high in the cycle after edge E0+NSL, i.e. NSL cycles after start was accepted.
- sum, c_out and ovf hold their values until the next completion. They are not cleared on start.
- start while busy = 1: ignored; operands are not recaptured.
- start during the done cycle: accepted, because busy = 0 then. This allows back-to-back operations with no gap. done and the new busy are both high in the cycle after that edge.
- Operand inputs may change freely after capture.
- rst asserted mid-operation: immediate return to reset values; the operation is lost and done does not pulse.
- CHUNK = WIDTH: NSL = 1, so done follows start by one cycle.
- Arithmetic is unsigned modulo 2^WIDTH, with c_out carrying the extra bit.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- Defined:
  - At completion, ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]). This is two's-complement overflow, computed from the captured operand MSBs.
  - The operand MSBs are held in a dedicated register at capture.
  - ovf holds like sum; reset 0.
- Undefined:
  - ovf is tied to 0.
  - The MSB capture register is not built.
  - Port list is unchanged.

Test Plan:
- Full-width carry (WIDTH=8, CHUNK=1): a=8'hFF, b=8'h01, c_in=0, start one cycle → busy for 8 cycles; done pulses once 8 cycles after start edge; sum=8'h00, c_out=1.
- Signed overflow (WIDTH=8, CHUNK=1, SERIAL_ADD_OVF_EN defined): a=8'h7F, b=8'h01, c_in=0 → sum=8'h80, c_out=0, ovf=1. Same stimulus with macro undefined → ovf=0.
- Wide slices (WIDTH=8, CHUNK=4): a=8'h3C, b=8'hC5, c_in=1 → done 2 cycles after start; sum=8'h02, c_out=1.
- Ignored start (WIDTH=8, CHUNK=1): start a=8'h10, b=8'h20; re-assert start with a=8'hFF, b=8'hFF at cycle 3 → result sum=8'h30, c_out=0; only one done pulse.
- Back-to-back (WIDTH=8, CHUNK=1): assert start with a=8'h05, b=8'h0A in the done cycle of a prior add → prior result visible during done; new done 8 cycles later with sum=8'h0F.
- Reset mid-operation: rst pulsed at cycle 4 of an 8-cycle add → busy, done, sum, c_out and ovf all 0 immediately; no done pulse follows; next start completes normally.
